gate_sweep_ctrl: RTL and testbench
==================================

# gate_sweep_ctrl

Sequencer that exhaustively exercises the 3-input combinational gate block (inputs a, b, c; output q) in hardware. On a start request it drives all 8 input combinations in ascending order and holds each for a programmable settle time. It samples q at the end of each hold and compares the captured truth table against a reference table latched at start. It sits between a host/control register interface and one gate instance, and replaces the fixed-delay stimulus sequence with a self-checking, clocked controller.

## Interface

- HOLD_CYCLES, 4, clock cycles each vector is held before q is sampled (legal range 1..16)
- STOP_ON_FAIL, 0, 1 = end the sweep at the first mismatch; 0 = always sweep all 8 vectors

- clk  input  1  rising-edge clock, the only clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a sweep; accepted only in IDLE
- abort  input  1  synchronous abort of a running sweep
- expected  input  8  reference truth table; bit i = expected q for vector i; latched on start acceptance
- q  input  1  gate output (combinational function of a, b, c)
- a  output  1  gate input, vector bit 2 (MSB)
- b  output  1  gate input, vector bit 1
- c  output  1  gate input, vector bit 0 (LSB)
- busy  output  1  high while a sweep is running
- done  output  1  one-cycle pulse when a sweep completes (not on abort)
- pass  output  1  result of last completed sweep: 1 = no mismatches
- captured  output  8  captured truth table; bit i = sampled q for vector i
- fail_count  output  4  number of mismatching vectors in last sweep (0..8)
- first_fail  output  3  index of first mismatching vector; 0 when pass=1

## Operation

- States: IDLE, RUN, DONE.
- IDLE: a=b=c=0, busy=0. If start=1 and abort=0, then at the next edge: latch expected, clear captured, fail_count and first_fail, set idx=0, hold_cnt=0, {a,b,c}=idx, pass=0, and go to RUN.
- RUN: {a,b,c} = idx (3-bit, a = MSB). Each edge with hold_cnt < HOLD_CYCLES-1 increments hold_cnt.
- RUN, edge with hold_cnt == HOLD_CYCLES-1 (sample edge):
  - captured[idx] <= q.
  - If q != expected_latched[idx]: fail_count increments. If this is the first mismatch, first_fail <= idx.
  - If idx==7, or STOP_ON_FAIL=1 and a mismatch occurred: go to DONE.
  - Otherwise idx increments, hold_cnt=0, and the new vector is driven.
- DONE: lasts exactly one cycle. done=1, busy=0, a=b=c=0, pass = (fail_count==0 and all 8 vectors swept). The next state is IDLE.
- Result outputs (pass, captured, fail_count, first_fail) hold their values until the next accepted start.
- start while in RUN or DONE is ignored and is not queued.
- abort=1 in RUN: at the next edge go to IDLE with busy=0 and pass=0; done is not pulsed. captured and fail_count keep their partial values. In IDLE, abort blocks start; abort wins a simultaneous start.
- The expected input may change during RUN with no effect, because it is latched at start.
- idx never wraps. 7 is the terminal vector.

## Timing

- Reset values: a=b=c=0, busy=0, done=0, pass=0, captured=0, fail_count=0, first_fail=0, state=IDLE, idx=0, hold_cnt=0.
- rst asserted mid-sweep returns the block to the reset values immediately, without waiting for a clock edge. No done pulse is produced.
- Start accepted at edge E0: busy is high from E0 through edge E0+8·HOLD_CYCLES. done is high for the single cycle after that edge.
- Full-sweep latency from start acceptance to done rising is 8·HOLD_CYCLES cycles; it is 32 for the default.
- Vector i is driven on edges E0+i·HOLD_CYCLES through E0+(i+1)·HOLD_CYCLES. q is sampled on the last of those edges, which gives the gate HOLD_CYCLES-1 full cycles of settle before the sampling cycle.
- With STOP_ON_FAIL=1 and first mismatch at vector k, done is high in the cycle after edge E0+(k+1)·HOLD_CYCLES.
- A back-to-back sweep is possible: start is accepted in the IDLE cycle that immediately follows DONE.

## Test plan

- AND3 gate model, expected=8'h80, HOLD_CYCLES=4 -> done 32 cycles after start; captured=8'h80, pass=1, fail_count=0. a,b,c step through 000..111 every 4 cycles.
- AND3 gate model, expected=8'h81 -> captured=8'h80, pass=0, fail_count=1, first_fail=0. With STOP_ON_FAIL=1: done after 4 cycles, fail_count=1, captured=8'h00.
- XOR3 gate model, expected=8'h00 -> captured=8'h96, fail_count=4, first_fail=1, pass=0.
- Abort asserted at cycle 10 of a sweep -> busy drops at the next edge, no done pulse, pass=0, a=b=c=0. Then start with abort held high in IDLE -> no sweep begins.
- Start pulsed again at cycles 5 and 20 of a running sweep -> ignored; done still occurs exactly once, at cycle 32.
- rst asserted mid-sweep at vector 3 -> all outputs return to their reset values without a clock edge. A new start afterwards gives a normal 32-cycle sweep.

Source files
------------

// File: rtl/gate_sweep_if.sv
// -----------------------------------------------------------------------------
// gate_sweep_if
// Bundles the signals between the sweep controller and its environment. The
// environment is the host control registers plus the gate under test.
//   start, abort, expected : host -> controller
//   q                      : gate -> controller
//   a, b, c                : controller -> gate (vector bits 2..0)
//   busy, done, pass,
//   captured, fail_count,
//   first_fail             : controller -> host status/result
// Modports: master = host/gate side, slave = sweep controller.
// -----------------------------------------------------------------------------
interface gate_sweep_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       q;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] captured;
  logic [3:0] fail_count;
  logic [2:0] first_fail;

  modport master (
    output start, abort, expected, q,
    input  a, b, c, busy, done, pass, captured, fail_count, first_fail
  );

  modport slave (
    input  start, abort, expected, q,
    output a, b, c, busy, done, pass, captured, fail_count, first_fail
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Clocked, self-checking sequencer for a 3-input combinational gate. On an
// accepted start it drives vectors 0..7 on {a,b,c}, holds each for
// HOLD_CYCLES clocks, samples q on the last edge of each hold and compares
// the result against a truth table latched at start.
//
// Parameters:
//   HOLD_CYCLES  : clocks each vector is held before q is sampled (1..16)
//   STOP_ON_FAIL : 1 = end the sweep at the first mismatching vector
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : gate_sweep_if.slave (start/abort/expected/q in,
//          a/b/c, busy, done, pass, captured, fail_count, first_fail out)
// -----------------------------------------------------------------------------
module gate_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  gate_sweep_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Terminal value of the per-vector hold counter; the edge on which the
  // counter equals this value is the sample edge.
  localparam logic [4:0] HOLD_LAST = 5'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] exp_latched;
  logic [2:0] idx;
  logic [4:0] hold_cnt;
  logic       pass_q;
  logic [7:0] captured_q;
  logic [3:0] fail_count_q;
  logic [2:0] first_fail_q;

  logic       accept;     // start taken this edge
  logic       sample;     // q is captured this edge
  logic       mismatch;   // current q disagrees with the latched reference
  logic       finish;     // this sample ends the sweep

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register sees the pre-edge values of the others, independent of process
  // evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and edge-qualifier decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    sample     = 1'b0;
    mismatch   = (bus.q != exp_latched[idx]);
    finish     = 1'b0;

    case (state)
      IDLE: begin
        // abort blocks start, so it wins a simultaneous request.
        if (bus.start && !bus.abort) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          sample = 1'b1;
          finish = (idx == 3'd7) || (STOP_ON_FAIL && mismatch);
          if (finish) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sweep datapath: vector index, hold timer, latched reference, results
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_latched  <= '0;
      idx          <= '0;
      hold_cnt     <= '0;
      pass_q       <= 1'b0;
      captured_q   <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else if (accept) begin
      exp_latched  <= bus.expected;
      idx          <= '0;
      hold_cnt     <= '0;
      pass_q       <= 1'b0;
      captured_q   <= '0;
      fail_count_q <= '0;
      first_fail_q <= '0;
    end else if (state == RUN) begin
      if (bus.abort) begin
        // Partial captured/fail_count are kept for inspection.
        idx      <= '0;
        hold_cnt <= '0;
        pass_q   <= 1'b0;
      end else if (sample) begin
        captured_q[idx] <= bus.q;
        if (mismatch) begin
          fail_count_q <= fail_count_q + 4'd1;
          if (fail_count_q == 4'd0) begin
            first_fail_q <= idx;
          end
        end
        hold_cnt <= '0;
        if (finish) begin
          // Pass needs a clean, complete sweep; an early stop always fails.
          pass_q <= (fail_count_q == 4'd0) && !mismatch && (idx == 3'd7);
          idx    <= '0;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        hold_cnt <= hold_cnt + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: the gate sees the vector only while running, zero otherwise.
  // ---------------------------------------------------------------------------
  assign {bus.a, bus.b, bus.c} = (state == RUN) ? idx : 3'b000;
  assign bus.busy              = (state == RUN);
  assign bus.done              = (state == DONE);
  assign bus.pass              = pass_q;
  assign bus.captured          = captured_q;
  assign bus.fail_count        = fail_count_q;
  assign bus.first_fail        = first_fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_ctrl
// Two controllers share clock, reset and the gate truth table:
//   u_dut    : HOLD_CYCLES=4, STOP_ON_FAIL=0 (host start/abort)
//   u_dut_sf : HOLD_CYCLES=1, STOP_ON_FAIL=1 (own start, abort tied low)
// The gate under test is a lookup in gate_tt indexed by {a,b,c}. Expected
// results come from a truth-table walk over gate_tt and the reference.
// -----------------------------------------------------------------------------
module tb_gate_sweep_ctrl;

  localparam int H_M = 4;
  localparam int H_S = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start_sf;
  logic       abort;
  logic [7:0] expected;
  logic [7:0] gate_tt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gate_sweep_if m_if ();
  gate_sweep_if s_if ();

  assign m_if.start    = start;
  assign m_if.abort    = abort;
  assign m_if.expected = expected;
  assign m_if.q        = gate_tt[{m_if.a, m_if.b, m_if.c}];

  assign s_if.start    = start_sf;
  assign s_if.abort    = 1'b0;
  assign s_if.expected = expected;
  assign s_if.q        = gate_tt[{s_if.a, s_if.b, s_if.c}];

  gate_sweep_ctrl #(.HOLD_CYCLES(H_M), .STOP_ON_FAIL(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  gate_sweep_ctrl #(.HOLD_CYCLES(H_S), .STOP_ON_FAIL(1'b1)) u_dut_sf (
    .clk (clk),
    .rst (rst),
    .bus (s_if)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Walk the truth table in vector order: what the sweep should capture and
  // count after examining at most nvec vectors.
  task automatic model(input logic [7:0] tt, input logic [7:0] ex, input int nvec,
                       input bit stop, output logic [7:0] cap, output logic [3:0] fc,
                       output logic [2:0] ff, output bit ps, output int swept);
    cap   = '0;
    fc    = '0;
    ff    = '0;
    swept = 0;
    for (int i = 0; i < nvec; i++) begin
      cap[i] = tt[i];
      swept  = i + 1;
      if (tt[i] != ex[i]) begin
        if (fc == 4'd0) ff = 3'(i);
        fc = fc + 4'd1;
        if (stop) break;
      end
    end
    ps = (fc == 4'd0) && (swept == 8);
  endtask

  // Called at a negedge; returns at the negedge of the IDLE cycle after DONE,
  // so a following call exercises a back-to-back start.
  task automatic run_sweep(input logic [7:0] tt, input logic [7:0] ex, input bit noise);
    logic [7:0] m_cap, s_cap;
    logic [3:0] m_fc, s_fc;
    logic [2:0] m_ff, s_ff;
    bit         m_ps, s_ps;
    int         m_sw, s_sw;
    int         m_lat = -1;
    int         s_lat = -1;
    int         seq_bad = 0;

    model(tt, ex, 8, 1'b0, m_cap, m_fc, m_ff, m_ps, m_sw);
    model(tt, ex, 8, 1'b1, s_cap, s_fc, s_ff, s_ps, s_sw);

    gate_tt  = tt;
    expected = ex;
    start    = 1'b1;
    start_sf = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    start_sf = 1'b0;

    for (int k = 0; k < 8 * H_M + 4 && m_lat < 0; k++) begin
      if (s_lat < 0) begin
        if (s_if.done) begin
          s_lat = k;
          check("sf_captured",   s_if.captured,   s_cap);
          check("sf_fail_count", s_if.fail_count, s_fc);
          check("sf_first_fail", s_if.first_fail, s_ff);
          check("sf_pass",       s_if.pass,       s_ps);
          check("sf_idle_out",   {s_if.busy, s_if.a, s_if.b, s_if.c}, 0);
        end else if (!s_if.busy || {s_if.a, s_if.b, s_if.c} != 3'(k / H_S)) begin
          seq_bad++;
        end
      end
      if (m_if.done) begin
        m_lat = k;
      end else begin
        if (!m_if.busy || {m_if.a, m_if.b, m_if.c} != 3'(k / H_M)) seq_bad++;
        if (noise) begin
          start    = 1'($urandom_range(0, 1));
          expected = 8'($urandom);
        end
        @(negedge clk);
      end
    end

    check("latency",    m_lat, 8 * H_M);
    check("sf_latency", s_lat, s_sw * H_S);
    check("vector_seq", seq_bad, 0);
    check("captured",   m_if.captured,   m_cap);
    check("fail_count", m_if.fail_count, m_fc);
    check("first_fail", m_if.first_fail, m_ff);
    check("pass",       m_if.pass,       m_ps);
    check("done_out",   {m_if.busy, m_if.a, m_if.b, m_if.c}, 0);

    // A start during DONE must be dropped, not queued.
    start = noise;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", {m_if.done, m_if.busy}, 0);
    check("pass_held",      m_if.pass, m_ps);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p_cap, tt, ex;
    logic [3:0] p_fc;
    logic [2:0] p_ff;
    bit         p_ps;
    int         p_sw;
    int         bad;

    rst      = 1'b1;
    start    = 1'b0;
    start_sf = 1'b0;
    abort    = 1'b0;
    expected = '0;
    gate_tt  = '0;

    repeat (2) @(negedge clk);
    check("reset_outs", {m_if.busy, m_if.done, m_if.pass, m_if.a, m_if.b, m_if.c,
                         m_if.captured, m_if.fail_count, m_if.first_fail}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {m_if.busy, m_if.done}, 0);

    // AND3 against its own table, then a wrong reference bit, then XOR3.
    run_sweep(8'h80, 8'h80, 1'b0);
    check("and3_pass_seen", m_if.pass, 1);

    // Abort at cycle 10: vectors 0 and 1 are already sampled.
    gate_tt  = 8'($urandom);
    expected = 8'($urandom);
    model(gate_tt, expected, 2, 1'b0, p_cap, p_fc, p_ff, p_ps, p_sw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("abort_outs",     {m_if.busy, m_if.done, m_if.pass, m_if.a, m_if.b, m_if.c}, 0);
    check("abort_captured", m_if.captured,   p_cap);
    check("abort_failcnt",  m_if.fail_count, p_fc);
    start = 1'b1;
    bad   = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_if.busy || m_if.done) bad++;
    end
    check("abort_blocks_start", bad, 0);
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);

    run_sweep(8'h80, 8'h81, 1'b0);
    run_sweep(8'h96, 8'h00, 1'b1);

    // Asynchronous reset at vector 3, checked before the next rising edge.
    gate_tt  = 8'hFF;
    expected = 8'hFF;
    start    = 1'b1;
    start_sf = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    start_sf = 1'b0;
    repeat (13) @(negedge clk);
    check("pre_rst_vector", {m_if.a, m_if.b, m_if.c}, 3);
    check("pre_rst_capt",   m_if.captured, 8'h07);
    check("pre_rst_sf_pass", s_if.pass, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_m", {m_if.busy, m_if.done, m_if.pass, m_if.a, m_if.b, m_if.c,
                          m_if.captured, m_if.fail_count, m_if.first_fail}, 0);
    check("async_rst_s", {s_if.busy, s_if.done, s_if.pass, s_if.a, s_if.b, s_if.c,
                          s_if.captured, s_if.fail_count, s_if.first_fail}, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    run_sweep(8'h80, 8'h80, 1'b0);

    // Random gates and references: exact, one flipped bit, or unrelated.
    for (int n = 0; n < 12; n++) begin
      tt = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       ex = tt;
        1:       ex = tt ^ (8'h01 << $urandom_range(0, 7));
        default: ex = 8'($urandom);
      endcase
      run_sweep(tt, ex, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
